// File: rtl/fifo_burst_arbiter_if.sv
// Requester and coefficient-FIFO signal bundle for fifo_burst_arbiter.
// The master side is the environment (producers plus FIFO); the slave side is the arbiter.
interface fifo_burst_arbiter_if #(
  parameter int width_p    = 16,
  parameter int burst_n_p  = 4,
  parameter int req_n_p    = 2,
  parameter int id_width_p = $clog2(req_n_p)
);
  logic [req_n_p-1:0][burst_n_p-1:0][width_p-1:0] req_data_i;
  logic [req_n_p-1:0]                              req_valid_i;
  logic [req_n_p-1:0]                              req_ready_o;
  logic [width_p-1:0]                              fifo_data_o;
  logic                                            fifo_valid_o;
  logic                                            fifo_ready_i;
  logic [id_width_p-1:0]                           grant_id_o;
  logic                                            busy_o;
  logic                                            done_o;

  modport master (
    output req_data_i, req_valid_i, fifo_ready_i,
    input  req_ready_o, fifo_data_o, fifo_valid_o, grant_id_o, busy_o, done_o
  );

  modport slave (
    input  req_data_i, req_valid_i, fifo_ready_i,
    output req_ready_o, fifo_data_o, fifo_valid_o, grant_id_o, busy_o, done_o
  );
endinterface

// File: rtl/fifo_burst_arbiter.sv
// Round-robin arbiter: captures one requester's coefficient bundle in a single
// handshake, then serializes it word by word into a shared valid-ready FIFO.
module fifo_burst_arbiter #(
  parameter int width_p    = 16,
  parameter int burst_n_p  = 4,
  parameter int req_n_p    = 2,
  parameter int id_width_p = $clog2(req_n_p)
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  fifo_burst_arbiter_if.slave bus
);
  localparam int idx_w_p = $clog2(burst_n_p);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                              state;
  logic [idx_w_p-1:0]                  idx;
  logic [id_width_p-1:0]               last_grant;
  logic [id_width_p-1:0]               grant_id;
  logic [burst_n_p-1:0][width_p-1:0]   buffer;

  logic [id_width_p-1:0]               pick;
  logic                                found;
  logic [req_n_p-1:0]                  req_ready;
  logic                                last_word;
  logic                                accept;

  // Scan from the highest offset down so the nearest requester after last_grant wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = req_n_p; k >= 1; k--) begin
      if (bus.req_valid_i[(int'(last_grant) + k) % req_n_p]) begin
        pick  = id_width_p'((int'(last_grant) + k) % req_n_p);
        found = 1'b1;
      end
    end
  end

  // Gated by reset so no handshake can complete while the arbiter is held in reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && reset_n_i) begin
      req_ready[pick] = 1'b1;
    end
  end

  assign last_word = (idx == idx_w_p'(burst_n_p - 1));
  assign accept    = (state == XFER) && bus.fifo_ready_i;

  assign bus.req_ready_o  = req_ready;
  assign bus.fifo_valid_o = (state == XFER);
  assign bus.fifo_data_o  = (state == XFER) ? buffer[idx] : '0;
  assign bus.busy_o       = (state == XFER);
  assign bus.done_o       = accept && last_word;
  assign bus.grant_id_o   = grant_id;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      idx        <= '0;
      last_grant <= id_width_p'(req_n_p - 1);
      grant_id   <= '0;
      buffer     <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        buffer     <= bus.req_data_i[pick];
        grant_id   <= pick;
        last_grant <= pick;
        idx        <= '0;
        state      <= XFER;
      end
    end else if (accept) begin
      if (last_word) begin
        idx   <= '0;
        state <= IDLE;
      end else begin
        idx <= idx + idx_w_p'(1);
      end
    end
  end
endmodule

// File: doc/fifo_burst_arbiter.md
Name: fifo_burst_arbiter

Overview:
- Round-robin arbiter that shares one single-word, valid-ready coefficient FIFO among req_n_p requesters.
- Each requester presents a bundle of burst_n_p coefficient words in parallel.
- The arbiter grants one requester, captures its bundle in one cycle, then serializes it into the FIFO one word per accepted cycle, element 0 first.
- It sits between the polynomial producers (NTT/multiply stages) and the shared coefficient FIFO.

Parameters:
- width_p, `BIT_WIDTH, bits per coefficient word.
- burst_n_p, `N_WRITE, words per bundle; must be >= 2.
- req_n_p, 2, number of requesters; must be >= 2.
- id_width_p, $clog2(req_n_p), width of the grant index.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_n_i  in  1  reset, asynchronous, active-low.
- req_data_i  in  [req_n_p][burst_n_p][width_p]  bundle per requester; element 0 is sent first.
- req_valid_i  in  [req_n_p]  requester r has a bundle available.
- req_ready_o  out  [req_n_p]  one-hot; bundle r is accepted this cycle.
- fifo_data_o  out  width_p  word to the FIFO.
- fifo_valid_o  out  1  fifo_data_o is valid.
- fifo_ready_i  in  1  FIFO can accept a word this cycle.
- grant_id_o  out  id_width_p  index of the requester currently being serialized.
- busy_o  out  1  a bundle is being serialized.
- done_o  out  1  last word of a bundle is accepted this cycle.

Behaviour:
- Reset (reset_n_i low, asynchronous, any state):
  - state=IDLE, idx=0, last_grant=req_n_p-1, captured buffer cleared to 0.
  - All outputs 0: req_ready_o, fifo_valid_o, fifo_data_o, grant_id_o, busy_o, done_o.
  - A bundle in flight is discarded; no partial-burst resume after reset release.
- States: IDLE, XFER.
- IDLE:
  - If no req_valid_i is set: req_ready_o=0, stay in IDLE.
  - Otherwise pick the first r with req_valid_i[r]=1, searching last_grant+1, last_grant+2, ... modulo req_n_p.
  - req_ready_o[r]=1, combinationally, in this same cycle. The handshake completes in this cycle.
  - On the clock edge: capture req_data_i[r] into the buffer; set grant_id_o<=r, last_grant<=r, idx<=0; go to XFER.
  - fifo_valid_o=0 in IDLE.
- XFER:
  - fifo_valid_o=1, fifo_data_o=buffer[idx], busy_o=1, req_ready_o=0.
  - fifo_ready_i=1: word accepted, idx<=idx+1.
  - fifo_ready_i=0: hold idx; fifo_data_o stays stable.
  - fifo_ready_i=1 and idx==burst_n_p-1: done_o=1 (combinational); next state IDLE, idx<=0.
- Latency:
  - Grant in cycle T; first word valid in cycle T+1.
  - With no backpressure, a bundle occupies burst_n_p+1 cycles (one IDLE grant cycle plus burst_n_p XFER cycles). Peak throughput is burst_n_p/(burst_n_p+1) words per cycle.
- Fairness:
  - A requester holding valid is granted within req_n_p grants.
  - Requesters are never granted back-to-back while another requester is valid.
- Atomicity:
  - A bundle is never interleaved with another bundle.
  - Changes on req_data_i or req_valid_i during XFER have no effect.
- The FIFO full condition is expressed only through fifo_ready_i. The arbiter stalls indefinitely with no data loss or duplication.
- Requester side follows valid-ready: a requester may drop req_valid_i at any time before its handshake. The arbiter never grants a requester whose valid is low in the grant cycle.
- Width: idx is $clog2(burst_n_p) bits and wraps only via the return to IDLE. No arithmetic is performed on data.

Test Plan (width_p=16, burst_n_p=4, req_n_p=2):
- After reset, req0 valid with {A0,A1,A2,A3}, fifo_ready_i=1 → req_ready_o=01 in cycle 0; fifo_data_o=A0,A1,A2,A3 in cycles 1-4; done_o=1 in cycle 4; busy_o=0 in cycle 5.
- req0 and req1 both valid continuously → grants alternate 0,1,0,1. The output stream is A0..A3, B0..B3, A0..A3, with exactly one IDLE gap cycle between bundles.
- During XFER of req0, drive fifo_ready_i=0 for 3 cycles at idx=2 → fifo_data_o holds A2 for those 3 cycles. Exactly 4 words are accepted in total, with no duplicate or missing word.
- Change req_data_i[0] to all-ones mid-XFER → the remaining output words are still the captured A values.
- Assert reset_n_i low asynchronously (between edges) at idx=1 → all outputs go to 0 immediately. After release with req1 valid, the first grant goes to req1 only if req0 is not valid (last_grant=1 restored, so req0 has priority when both are valid).
- req1 raises valid for one cycle while in XFER serving req0, then drops it → req1 is not granted; req_ready_o stays 00.
